cache_mem_arbiter: RTL and testbench

Shares the single main-memory block port between two cache controllers: requester 0 is the data cache, requester 1 is the instruction cache. Each requester posts a block transaction: an optional dirty write-back, an optional refill read, or both. The arbiter serialises transactions with round-robin priority and sequences each one against memory as write-back first, then refill. It sits between the cache controllers' mem_* outputs and the main-memory model.

---
 rtl/cache_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Purpose: serialise block transactions from two cache controllers onto one memory port, round-robin.
// Latency: done at grant+L+1 for one phase, grant+2L+1 for write-back plus refill (L = memory ack latency).
// Backpressure: requesters hold level requests until their done pulse; memory enables held until mem_ack.
module cache_mem_arbiter #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_rd_en,
  input  logic                 req0_wr_en,
  input  logic [PA_WIDTH-1:0]  req0_addr,
  input  logic [PA_WIDTH-1:0]  req0_wb_addr,
  input  logic [BLK_WIDTH-1:0] req0_wr_blk,
  output logic                 req0_done,
  input  logic                 req1_rd_en,
  input  logic                 req1_wr_en,
  input  logic [PA_WIDTH-1:0]  req1_addr,
  input  logic [PA_WIDTH-1:0]  req1_wb_addr,
  input  logic [BLK_WIDTH-1:0] req1_wr_blk,
  output logic                 req1_done,
  output logic [BLK_WIDTH-1:0] rd_blk,
  output logic                 busy,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_blk,
  input  logic [BLK_WIDTH-1:0] mem_rd_blk,
  input  logic                 mem_ack
);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t               state, state_nx;
  logic                 owner, owner_nx;
  logic                 last, last_nx;
  logic                 rd_flag, rd_flag_nx;
  logic                 wr_flag, wr_flag_nx;
  logic [PA_WIDTH-1:0]  addr_q, addr_nx;
  logic [PA_WIDTH-1:0]  wb_addr_q, wb_addr_nx;
  logic [BLK_WIDTH-1:0] wr_blk_q, wr_blk_nx;
  logic                 req0_done_nx, req1_done_nx;
  logic [BLK_WIDTH-1:0] rd_blk_nx;
  logic                 busy_nx;
  logic [PA_WIDTH-1:0]  mem_addr_nx;
  logic                 mem_rd_en_nx, mem_wr_en_nx;
  logic                 pend0, pend1, gnt;

  // The latched write-back data register drives the memory data bus directly;
  // it only matters to memory while mem_wr_en is high.
  assign mem_wr_blk = wr_blk_q;

  assign pend0 = req0_rd_en | req0_wr_en;
  assign pend1 = req1_rd_en | req1_wr_en;

  // State register and all registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      rd_flag   <= 1'b0;
      wr_flag   <= 1'b0;
      addr_q    <= '0;
      wb_addr_q <= '0;
      wr_blk_q  <= '0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      rd_blk    <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      last      <= last_nx;
      rd_flag   <= rd_flag_nx;
      wr_flag   <= wr_flag_nx;
      addr_q    <= addr_nx;
      wb_addr_q <= wb_addr_nx;
      wr_blk_q  <= wr_blk_nx;
      req0_done <= req0_done_nx;
      req1_done <= req1_done_nx;
      rd_blk    <= rd_blk_nx;
      busy      <= busy_nx;
      mem_addr  <= mem_addr_nx;
      mem_rd_en <= mem_rd_en_nx;
      mem_wr_en <= mem_wr_en_nx;
    end
  end

  // Next-state and next-output logic: arbitrate in IDLE, then write-back, refill, done.
  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    last_nx      = last;
    rd_flag_nx   = rd_flag;
    wr_flag_nx   = wr_flag;
    addr_nx      = addr_q;
    wb_addr_nx   = wb_addr_q;
    wr_blk_nx    = wr_blk_q;
    req0_done_nx = 1'b0;
    req1_done_nx = 1'b0;
    rd_blk_nx    = rd_blk;
    busy_nx      = busy;
    mem_addr_nx  = mem_addr;
    mem_rd_en_nx = mem_rd_en;
    mem_wr_en_nx = mem_wr_en;
    // On a tie the requester that was not served last wins.
    gnt          = (pend0 && pend1) ? ~last : pend1;

    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (pend0 || pend1) begin
          owner_nx   = gnt;
          rd_flag_nx = gnt ? req1_rd_en   : req0_rd_en;
          wr_flag_nx = gnt ? req1_wr_en   : req0_wr_en;
          addr_nx    = gnt ? req1_addr    : req0_addr;
          wb_addr_nx = gnt ? req1_wb_addr : req0_wb_addr;
          wr_blk_nx  = gnt ? req1_wr_blk  : req0_wr_blk;
          busy_nx    = 1'b1;
          state_nx   = (gnt ? req1_wr_en : req0_wr_en) ? WB : FILL;
        end
      end
      WB: begin
        // First WB cycle raises the enable; ack only counts once it is up.
        if (!mem_wr_en) begin
          mem_wr_en_nx = 1'b1;
          mem_addr_nx  = wb_addr_q;
        end else if (mem_ack) begin
          mem_wr_en_nx = 1'b0;
          if (rd_flag) begin
            // Refill starts on the same edge the write-back retires.
            mem_rd_en_nx = 1'b1;
            mem_addr_nx  = addr_q;
            state_nx     = FILL;
          end else begin
            req0_done_nx = ~owner;
            req1_done_nx = owner;
            state_nx     = DONE;
          end
        end
      end
      FILL: begin
        if (!mem_rd_en) begin
          mem_rd_en_nx = 1'b1;
          mem_addr_nx  = addr_q;
        end else if (mem_ack) begin
          mem_rd_en_nx = 1'b0;
          rd_blk_nx    = mem_rd_blk;
          req0_done_nx = ~owner;
          req1_done_nx = owner;
          state_nx     = DONE;
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        last_nx  = owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  localparam int PA  = 32;
  localparam int BLK = 512;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_rd_en, req0_wr_en, req1_rd_en, req1_wr_en;
  logic [PA-1:0]  req0_addr, req0_wb_addr, req1_addr, req1_wb_addr;
  logic [BLK-1:0] req0_wr_blk, req1_wr_blk;
  logic           req0_done, req1_done, busy;
  logic [BLK-1:0] rd_blk, mem_wr_blk, mem_rd_blk;
  logic [PA-1:0]  mem_addr;
  logic           mem_rd_en, mem_wr_en, mem_ack;

  int total = 0;
  int bad   = 0;

  // memory model controls
  int lat      = 1;
  bit model_en = 1'b1;
  int m_cnt    = 0;
  int m_kind   = 0;
  int m_prev   = 0;
  bit m_acked  = 1'b0;

  logic [BLK-1:0] pat_a5, pat_11, pat_c3, pat_5a;

  cache_mem_arbiter #(.PA_WIDTH(PA), .BLK_WIDTH(BLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_rd_en(req0_rd_en), .req0_wr_en(req0_wr_en), .req0_addr(req0_addr),
    .req0_wb_addr(req0_wb_addr), .req0_wr_blk(req0_wr_blk), .req0_done(req0_done),
    .req1_rd_en(req1_rd_en), .req1_wr_en(req1_wr_en), .req1_addr(req1_addr),
    .req1_wb_addr(req1_wb_addr), .req1_wr_blk(req1_wr_blk), .req1_done(req1_done),
    .rd_blk(rd_blk), .busy(busy), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wr_blk(mem_wr_blk), .mem_rd_blk(mem_rd_blk),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: ack is sampled on the L-th rising edge after the enable rises.
  always @(posedge clk) begin
    #1;
    if (model_en) begin
      mem_ack = 1'b0;
      m_kind  = mem_wr_en ? 1 : (mem_rd_en ? 2 : 0);
      if (m_kind == 0 || m_kind != m_prev) begin
        m_cnt   = 0;
        m_acked = 1'b0;
      end
      m_prev = m_kind;
      if (m_kind != 0 && !m_acked) begin
        m_cnt++;
        if (m_cnt == lat) begin
          mem_ack = 1'b1;
          m_acked = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    total++;
    if ({req0_done, req1_done, busy, mem_rd_en, mem_wr_en} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {req0_done, req1_done, busy, mem_rd_en, mem_wr_en});
    end
    total++;
    if (mem_addr !== '0) begin
      bad++; $display("FAIL reset_addr: got %h want 0", mem_addr);
    end
    total++;
    if (rd_blk !== '0 || mem_wr_blk !== '0) begin
      bad++; $display("FAIL reset_data: rd_blk/mem_wr_blk not zero");
    end
  endtask

  task automatic test_read0();
    lat = 3;
    mem_rd_blk = pat_a5;
    req0_addr = 32'h0000_1040;
    req0_rd_en = 1'b1;
    step();  // grant edge
    total++;
    if ({busy, mem_rd_en, mem_wr_en} !== 3'b100) begin
      bad++; $display("FAIL rd0_grant: got %b want 100", {busy, mem_rd_en, mem_wr_en});
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0000_1040 || req0_done !== 1'b0) begin
        bad++;
        $display("FAIL rd0_phase%0d: rd_en=%b addr=%h done=%b want 1 00001040 0", i, mem_rd_en, mem_addr, req0_done);
      end
    end
    step();  // grant + 4
    total++;
    if ({req0_done, req1_done, busy, mem_rd_en} !== 4'b1010) begin
      bad++; $display("FAIL rd0_done: got %b want 1010", {req0_done, req1_done, busy, mem_rd_en});
    end
    total++;
    if (rd_blk !== pat_a5) begin
      bad++; $display("FAIL rd0_data: got %h want %h", rd_blk, pat_a5);
    end
    req0_rd_en = 1'b0;
    step();
    total++;
    if ({req0_done, busy} !== 2'b00) begin
      bad++; $display("FAIL rd0_idle: got %b want 00", {req0_done, busy});
    end
  endtask

  task automatic test_wr_rd1();
    lat = 2;
    mem_rd_blk = pat_c3;
    req1_wb_addr = 32'h0000_2000;
    req1_wr_blk = pat_11;
    req1_addr = 32'h0000_3000;
    req1_wr_en = 1'b1;
    req1_rd_en = 1'b1;
    step();  // grant
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i <= 2) begin
        total++;
        if ({mem_wr_en, mem_rd_en} !== 2'b10 || mem_addr !== 32'h0000_2000 || mem_wr_blk !== pat_11) begin
          bad++;
          $display("FAIL wr1_wb%0d: en=%b addr=%h want 10 00002000", i, {mem_wr_en, mem_rd_en}, mem_addr);
        end
      end else begin
        total++;
        if ({mem_wr_en, mem_rd_en} !== 2'b01 || mem_addr !== 32'h0000_3000) begin
          bad++;
          $display("FAIL wr1_fill%0d: en=%b addr=%h want 01 00003000", i, {mem_wr_en, mem_rd_en}, mem_addr);
        end
      end
    end
    step();  // grant + 5
    total++;
    if ({req1_done, req0_done, busy} !== 3'b101 || rd_blk !== pat_c3) begin
      bad++;
      $display("FAIL wr1_done: done1/done0/busy=%b want 101 rd_blk=%h", {req1_done, req0_done, busy}, rd_blk);
    end
    req1_wr_en = 1'b0;
    req1_rd_en = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    int ord[2];
    int n;
    bit exp_both[3];
    exp_both[0] = 1'b1;
    exp_both[1] = 1'b0;
    exp_both[2] = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    lat = 1;
    mem_rd_blk = pat_5a;
    req0_addr = 32'h0000_0100;
    req1_addr = 32'h0000_0200;
    step();
    for (int ph = 0; ph < 3; ph++) begin
      n = 0;
      ord[0] = -1;
      ord[1] = -1;
      req0_rd_en = 1'b1;
      req1_rd_en = exp_both[ph];
      for (int c = 0; c < 40 && (req0_rd_en || req1_rd_en); c++) begin
        step();
        total++;
        if ((req0_done && req1_done) || (mem_rd_en && mem_wr_en)) begin
          bad++;
          $display("FAIL fair_excl: done0=%b done1=%b rd=%b wr=%b", req0_done, req1_done, mem_rd_en, mem_wr_en);
        end
        if (req0_done && n < 2) begin ord[n] = 0; n++; req0_rd_en = 1'b0; end
        if (req1_done && n < 2) begin ord[n] = 1; n++; req1_rd_en = 1'b0; end
      end
      req0_rd_en = 1'b0;
      req1_rd_en = 1'b0;
      step();
      total++;
      if (ph == 0 && (n !== 2 || ord[0] !== 0 || ord[1] !== 1)) begin
        bad++; $display("FAIL fair_first: n=%0d order=%0d,%0d want 2 0,1", n, ord[0], ord[1]);
      end else if (ph == 1 && (n !== 1 || ord[0] !== 0)) begin
        bad++; $display("FAIL fair_single: n=%0d first=%0d want 1 0", n, ord[0]);
      end else if (ph == 2 && (n !== 2 || ord[0] !== 1 || ord[1] !== 0)) begin
        bad++; $display("FAIL fair_second: n=%0d order=%0d,%0d want 2 1,0", n, ord[0], ord[1]);
      end
    end
  endtask

  task automatic test_addr_latch();
    lat = 2;
    mem_rd_blk = pat_5a;
    req0_addr = 32'h0000_1040;
    req0_rd_en = 1'b1;
    step();  // grant
    req0_addr = 32'h0000_5000;
    for (int i = 1; i <= 2; i++) begin
      step();
      total++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0000_1040) begin
        bad++; $display("FAIL latch_addr%0d: rd_en=%b addr=%h want 1 00001040", i, mem_rd_en, mem_addr);
      end
    end
    step();
    total++;
    if (req0_done !== 1'b1 || rd_blk !== pat_5a) begin
      bad++; $display("FAIL latch_done: done0=%b want 1", req0_done);
    end
    req0_rd_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    lat = 50;
    req0_addr = 32'h0000_7000;
    req0_rd_en = 1'b1;
    step();
    step();
    step();
    total++;
    if (mem_rd_en !== 1'b1) begin
      bad++; $display("FAIL rstmid_fill: rd_en=%b want 1", mem_rd_en);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_rd_en, mem_wr_en, busy, req0_done, req1_done} !== 5'b0) begin
      bad++; $display("FAIL rstmid_async: got %b want 00000", {mem_rd_en, mem_wr_en, busy, req0_done, req1_done});
    end
    req0_rd_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    lat = 1;
    step();
    total++;
    if ({req0_done, req1_done, busy} !== 3'b000) begin
      bad++; $display("FAIL rstmid_nodone: got %b want 000", {req0_done, req1_done, busy});
    end
    mem_rd_blk = pat_c3;
    req0_addr = 32'h0000_0100;
    req1_addr = 32'h0000_0200;
    req0_rd_en = 1'b1;
    req1_rd_en = 1'b1;
    step();  // grant
    step();
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0000_0100) begin
      bad++; $display("FAIL rstmid_prio: addr=%h want 00000100", mem_addr);
    end
    step();
    total++;
    if ({req0_done, req1_done} !== 2'b10) begin
      bad++; $display("FAIL rstmid_done0: got %b want 10", {req0_done, req1_done});
    end
    req0_rd_en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (req1_done) seen = 1'b1;
    end
    req1_rd_en = 1'b0;
    total++;
    if (!seen) begin
      bad++; $display("FAIL rstmid_done1: got none want req1_done");
    end
    step();
  endtask

  task automatic test_ack_idle();
    model_en = 1'b0;
    mem_rd_blk = pat_a5;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({busy, mem_rd_en, mem_wr_en, req0_done, req1_done} !== 5'b0) begin
        bad++; $display("FAIL ackidle_%0d: got %b want 00000", i, {busy, mem_rd_en, mem_wr_en, req0_done, req1_done});
      end
      step();
    end
    model_en = 1'b1;
    lat = 1;
    req1_wb_addr = 32'h0000_4000;
    req1_wr_blk = pat_11;
    req1_wr_en = 1'b1;
    step();  // grant
    step();
    total++;
    if ({mem_wr_en, mem_rd_en} !== 2'b10 || mem_addr !== 32'h0000_4000 || mem_wr_blk !== pat_11) begin
      bad++; $display("FAIL wronly_wb: en=%b addr=%h want 10 00004000", {mem_wr_en, mem_rd_en}, mem_addr);
    end
    step();
    total++;
    if ({req1_done, req0_done, mem_wr_en, mem_rd_en} !== 4'b1000) begin
      bad++; $display("FAIL wronly_done: got %b want 1000", {req1_done, req0_done, mem_wr_en, mem_rd_en});
    end
    total++;
    if (rd_blk !== pat_c3) begin
      bad++; $display("FAIL wronly_rdblk: got %h want %h", rd_blk, pat_c3);
    end
    req1_wr_en = 1'b0;
    step();
  endtask

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_11 = {64{8'h11}};
    pat_c3 = {64{8'hC3}};
    pat_5a = {64{8'h5A}};
    rst_n = 1'b0;
    req0_rd_en = 1'b0; req0_wr_en = 1'b0; req1_rd_en = 1'b0; req1_wr_en = 1'b0;
    req0_addr = '0; req0_wb_addr = '0; req1_addr = '0; req1_wb_addr = '0;
    req0_wr_blk = '0; req1_wr_blk = '0;
    mem_rd_blk = '0;
    mem_ack = 1'b0;
    test_reset();
    test_read0();
    test_wr_rd1();
    test_fairness();
    test_addr_latch();
    test_reset_mid();
    test_ack_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
